// File: rtl/receive_engine_if.sv
// Processor-side and line-side signal bundle of the UART receive engine.
// The master side configures the frame and drives Rx/clr; the slave side returns the held frame.
interface receive_engine_if #(
  parameter int KW = 19
);
  logic          eight;
  logic          pen;
  logic          ohel;
  logic [KW-1:0] k;
  logic          Rx;
  logic          clr;
  logic [7:0]    UART_DS;
  logic          RxRdy;
  logic          PERR;
  logic          FERR;
  logic          OVF;

  modport master (
    output eight, pen, ohel, k, Rx, clr,
    input  UART_DS, RxRdy, PERR, FERR, OVF
  );

  modport slave (
    input  eight, pen, ohel, k, Rx, clr,
    output UART_DS, RxRdy, PERR, FERR, OVF
  );
endinterface

// File: rtl/receive_engine.sv
// UART receive engine: synchronises Rx, samples each bit at its midpoint using the bit time k,
// and holds the received byte plus RxRdy/PERR/FERR/OVF until the processor strobes clr.
module receive_engine #(
  parameter int KW = 19
) (
  input logic             clk,
  input logic             rst,
  receive_engine_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [KW-1:0] CNT_ZERO = {KW{1'b0}};
  localparam logic [KW-1:0] CNT_ONE  = {{(KW-1){1'b0}}, 1'b1};

  // Odd parity select flips the expected XOR of data and parity bit from 0 to 1.
  function automatic logic parity_err(input logic [7:0] data, input logic pbit, input logic odd);
    return pbit != ((^data) ^ odd);
  endfunction

  state_t        state_q, state_d;
  logic [KW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic [9:0]    sr_q, sr_d;
  logic          rx_meta_q, rxs_q;
  logic [7:0]    ds_q, ds_d;
  logic          rdy_q, rdy_d;
  logic          perr_q, perr_d;
  logic          ferr_q, ferr_d;
  logic          ovf_q, ovf_d;

  logic [3:0]    n_s;
  logic [KW-1:0] half_s;
  logic [KW-1:0] last_s;
  logic [9:0]    frame_s;
  logic [7:0]    data_s;
  logic [3:0]    pidx_s;
  logic          pbit_s;
  logic          stop_s;

  // Frame geometry and right-justified view of the shift register.
  always_comb begin
    n_s     = 4'd8 + {3'd0, bus.eight} + {3'd0, bus.pen};
    half_s  = (bus.k >> 1) - CNT_ONE;
    last_s  = bus.k - CNT_ONE;
    frame_s = sr_q >> (4'd10 - n_s);
    data_s  = bus.eight ? frame_s[7:0] : {1'b0, frame_s[6:0]};
    pidx_s  = 4'd7 + {3'd0, bus.eight};
    pbit_s  = frame_s[pidx_s];
    stop_s  = frame_s[n_s - 4'd1];
  end

  // Next-state, counter and held-result logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sr_d    = sr_q;
    ds_d    = ds_q;
    rdy_d   = rdy_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    ovf_d   = ovf_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = CNT_ZERO;
        bit_d = 4'd0;
        if (!rxs_q) begin
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (cnt_q == half_s) begin
          cnt_d = CNT_ZERO;
          bit_d = 4'd0;
          // A start bit that is high again at its midpoint is a glitch, not a frame.
          if (!rxs_q) begin
            state_d = S_DATA;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DATA: begin
        if (cnt_q == last_s) begin
          cnt_d = CNT_ZERO;
          sr_d  = {rxs_q, sr_q[9:1]};
          bit_d = bit_q + 4'd1;
          if ((bit_q + 4'd1) == n_s) begin
            state_d = S_DONE;
          end else begin
            state_d = S_DATA;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Delivering a frame takes priority over a coincident clr.
    if (state_q == S_DONE) begin
      ds_d   = data_s;
      rdy_d  = 1'b1;
      perr_d = bus.pen & parity_err(data_s, pbit_s, bus.ohel);
      ferr_d = ~stop_s;
      ovf_d  = ovf_q | (rdy_q & ~bus.clr);
    end else if (bus.clr) begin
      rdy_d  = 1'b0;
      perr_d = 1'b0;
      ferr_d = 1'b0;
      ovf_d  = 1'b0;
    end else begin
      rdy_d  = rdy_q;
      ovf_d  = ovf_q;
    end
  end

  // State, counters, Rx synchroniser and held outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= CNT_ZERO;
      bit_q     <= 4'd0;
      sr_q      <= 10'h3FF;
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
      ds_q      <= 8'h00;
      rdy_q     <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      sr_q      <= sr_d;
      rx_meta_q <= bus.Rx;
      rxs_q     <= rx_meta_q;
      ds_q      <= ds_d;
      rdy_q     <= rdy_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.UART_DS = ds_q;
  assign bus.RxRdy   = rdy_q;
  assign bus.PERR    = perr_q;
  assign bus.FERR    = ferr_q;
  assign bus.OVF     = ovf_q;

endmodule

// File: tb/tb_receive_engine.sv
// Bench for receive_engine: directed frame table, multi-cycle corner sequences,
// and randomized frames checked against a spec-level model of the held flags.
module tb_receive_engine;
  localparam int KW = 19;

  logic clk = 1'b0;
  logic rst;
  receive_engine_if #(.KW(KW)) bus ();
  receive_engine #(.KW(KW)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rise_cyc = 0;
  int start_cyc = 0;
  logic rdy_prev = 1'b0;

  // Cycle stamp of the most recent RxRdy rising edge.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    rdy_prev <= bus.RxRdy;
    if (bus.RxRdy && !rdy_prev) rise_cyc <= cyc;
  end

  typedef struct {
    logic eight; logic pen; logic ohel; int k;
    logic [7:0] data; logic par; logic stop;
    logic [7:0] exp_ds; logic exp_perr; logic exp_ferr;
  } vec_t;
  vec_t vecs[5];

  logic [7:0] m_ds;
  logic m_rdy, m_perr, m_ferr, m_ovf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [7:0] ds, input logic rdy,
                           input logic perr, input logic ferr, input logic ovf);
    check({tag, ".UART_DS"}, {24'd0, bus.UART_DS}, {24'd0, ds});
    check({tag, ".RxRdy"}, {31'd0, bus.RxRdy}, {31'd0, rdy});
    check({tag, ".PERR"}, {31'd0, bus.PERR}, {31'd0, perr});
    check({tag, ".FERR"}, {31'd0, bus.FERR}, {31'd0, ferr});
    check({tag, ".OVF"}, {31'd0, bus.OVF}, {31'd0, ovf});
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic par, input logic stop);
    int nd;
    int kk;
    nd = bus.eight ? 8 : 7;
    kk = int'(bus.k);
    @(negedge clk);
    start_cyc = cyc;
    bus.Rx = 1'b0;
    repeat (kk) @(negedge clk);
    for (int i = 0; i < nd; i++) begin
      bus.Rx = data[i];
      repeat (kk) @(negedge clk);
    end
    if (bus.pen) begin
      bus.Rx = par;
      repeat (kk) @(negedge clk);
    end
    bus.Rx = stop;
    repeat (kk) @(negedge clk);
    bus.Rx = 1'b1;
  endtask

  task automatic set_cfg(input logic e, input logic p, input logic o, input int kk);
    bus.eight = e;
    bus.pen = p;
    bus.ohel = o;
    bus.k = KW'(kk);
  endtask

  initial begin
    int lat;
    int ones;
    logic [7:0] dm;
    logic e, p, o, par, stop;
    int kk;
    logic [7:0] d;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 109, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 109, 8'h25, 1'b1, 1'b1, 8'h25, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 109, 8'h25, 1'b0, 1'b1, 8'h25, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 109, 8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 109, 8'hA5, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b1};

    rst = 1'b0;
    bus.Rx = 1'b1;
    bus.clr = 1'b0;
    set_cfg(1'b1, 1'b0, 1'b0, 109);
    tick(3);
    check_out("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    tick(3);

    for (int i = 0; i < 5; i++) begin
      set_cfg(vecs[i].eight, vecs[i].pen, vecs[i].ohel, vecs[i].k);
      tick(2);
      send_frame(vecs[i].data, vecs[i].par, vecs[i].stop);
      tick(vecs[i].k + 8);
      check_out($sformatf("vec%0d", i), vecs[i].exp_ds, 1'b1, vecs[i].exp_perr, vecs[i].exp_ferr, 1'b0);
      if (i == 0) begin
        lat = rise_cyc - start_cyc;
        check("latency_in_window", {31'd0, (lat >= 1035 && lat <= 1041)}, 32'd1);
      end
      pulse_clr();
      check_out($sformatf("vec%0d_clr", i), vecs[i].exp_ds, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Overrun: second frame lands while the first is still unread.
    set_cfg(1'b1, 1'b0, 1'b0, 109);
    tick(2);
    send_frame(8'h3C, 1'b0, 1'b1);
    tick(117);
    send_frame(8'hC3, 1'b0, 1'b1);
    tick(117);
    check_out("ovf", 8'hC3, 1'b1, 1'b0, 1'b0, 1'b1);
    pulse_clr();
    check_out("ovf_clr", 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0);

    // Glitch shorter than half a bit time is a false start.
    @(negedge clk);
    bus.Rx = 1'b0;
    tick(20);
    bus.Rx = 1'b1;
    tick(218);
    check_out("false_start", 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0);

    // clr coinciding with the delivery cycle: delivery wins, no overrun.
    send_frame(8'h11, 1'b0, 1'b1);
    tick(117);
    fork
      send_frame(8'h5E, 1'b0, 1'b1);
      begin
        @(negedge clk);
        repeat (3 + 54 + 9 * 109) @(negedge clk);
        bus.clr = 1'b1;
        @(negedge clk);
        bus.clr = 1'b0;
      end
    join
    tick(117);
    check_out("clr_in_done", 8'h5E, 1'b1, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of the data bits.
    @(negedge clk);
    bus.Rx = 1'b0;
    tick(109 * 3);
    bus.Rx = 1'b1;
    rst = 1'b0;
    #1;
    check_out("rst_mid", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(3);
    rst = 1'b1;
    tick(5);
    send_frame(8'h96, 1'b0, 1'b1);
    tick(117);
    check_out("after_rst", 8'h96, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse_clr();

    m_ds = 8'h96; m_rdy = 1'b0; m_perr = 1'b0; m_ferr = 1'b0; m_ovf = 1'b0;
    for (int n = 0; n < 24; n++) begin
      e = 1'($urandom_range(0, 1));
      p = 1'($urandom_range(0, 1));
      o = 1'($urandom_range(0, 1));
      kk = int'($urandom_range(4, 24));
      d = 8'($urandom);
      par = 1'($urandom_range(0, 1));
      stop = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) begin
        pulse_clr();
        m_rdy = 1'b0; m_perr = 1'b0; m_ferr = 1'b0; m_ovf = 1'b0;
      end
      set_cfg(e, p, o, kk);
      tick(2);
      send_frame(d, par, stop);
      tick(kk + 8);
      dm = e ? d : {1'b0, d[6:0]};
      ones = $countones(dm);
      m_ds = dm;
      m_perr = p && (par != 1'((ones + (o ? 1 : 0)) % 2));
      m_ferr = !stop;
      m_ovf = m_ovf || m_rdy;
      m_rdy = 1'b1;
      check_out($sformatf("rand%0d", n), m_ds, m_rdy, m_perr, m_ferr, m_ovf);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/receive_engine.md
Name: receive_engine

Overview:
- UART receive engine; the receive-side counterpart of the transmit engine inside the full UART.
- Deserialises the Rx line using the same frame configuration (eight, pen, ohel) and the same bit-time count k as the transmitter.
- Presents the received byte and status flags (RxRdy, PERR, FERR, OVF) to the processor read path.
- Flags and data are held until the processor reads them with clr.

Parameters:
- KW, 19, width of the bit-time count input k.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- eight  input  1  1 = 8 data bits; 0 = 7 data bits.
- pen  input  1  1 = parity bit present.
- ohel  input  1  parity select: 1 = odd, 0 = even (ignored when pen=0).
- k  input  KW  bit time in clk cycles; valid range 4..2^KW-1.
- Rx  input  1  serial line, asynchronous, idle high.
- clr  input  1  one-cycle read strobe; clears RxRdy, PERR, FERR and OVF.
- UART_DS  output  8  received data, right-justified; bit 7 = 0 in 7-bit mode.
- RxRdy  output  1  a new frame is held in UART_DS.
- PERR  output  1  parity error on the held frame.
- FERR  output  1  stop bit sampled low.
- OVF  output  1  a frame completed while RxRdy was still set.

Behaviour:
- Reset (rst=0, asynchronous):
  - state = IDLE; bit counter and sample counter = 0; shift register = 10'h3FF.
  - Rx synchroniser flops = 1.
  - UART_DS = 8'h00; RxRdy = PERR = FERR = OVF = 0.
  - Reset asserted mid-frame abandons the frame; no flags are set.
- Rx synchroniser:
  - Rx passes through 2 flops (rxs) before any use; this adds 2 clk of latency.
- Frame length after the start bit: N = 7 + eight + pen + 1 stop.
  - 7N: N=8. 7P or 8N: N=9. 8P: N=10.
- Configuration (eight, pen, ohel, k) must be static during a frame.
- State IDLE:
  - Counters held at 0.
  - rxs = 0 -> go to START, sample counter = 0.
- State START:
  - Sample counter increments each clk.
  - At count = (k>>1)-1 (start-bit midpoint): counter -> 0.
  - If rxs = 0 -> go to DATA, bit counter = 0.
  - If rxs = 1 -> false start; go to IDLE and set no flags.
- State DATA:
  - Sample counter increments each clk.
  - At count = k-1: counter -> 0; shift rxs into bit 9 of the shift register (right shift); bit counter +1.
  - When the bit counter reaches N after a sample: go to DONE.
- State DONE (one cycle):
  - Right-justify the shift register: frame = sr >> (10-N), so the first data bit is at frame[0].
  - UART_DS = eight ? frame[7:0] : {1'b0, frame[6:0]}.
  - Parity bit = frame[7+eight] when pen=1.
  - Stop bit = frame[N-1].
  - PERR = pen & (parity bit != (^data ^ ohel)); even parity requires XOR of data and parity bits = 0, odd requires 1.
  - FERR = ~stop bit.
  - OVF = RxRdy & ~clr, sticky; an existing OVF=1 is kept.
  - RxRdy = 1. Next state IDLE.
  - A frame that fails FERR is still delivered with RxRdy = 1.
- Latency: RxRdy, UART_DS and the flags update on the clk edge after the stop-bit sample.
- clr:
  - On the next edge, RxRdy, PERR, FERR and OVF go to 0; UART_DS holds its value.
  - clr in the same cycle as DONE: the DONE update wins, so RxRdy=1 with the new frame's PERR/FERR; OVF is not set by that frame.
- Back-to-back frames: IDLE is reachable the cycle after DONE, so a start bit immediately after the stop midpoint is caught. Rx low at the stop midpoint followed by a continued low line is treated as a new start.

Test Plan:
- k=109, 8N, Rx frame of 8'hA5 LSB-first with stop=1 -> RxRdy=1 about 9.5*109+3 clk after the start edge; UART_DS=8'hA5; PERR=FERR=OVF=0.
- k=109, 7 bits, even parity (pen=1, ohel=0), send 7'h25 with parity bit 1 -> UART_DS=8'h25, PERR=0. Repeat with parity bit 0 -> PERR=1.
- 8 bits, odd parity, send 8'hA5 with parity 1 -> PERR=0; send with stop bit 0 -> FERR=1, RxRdy=1, UART_DS=8'hA5.
- Two 8N frames (8'h3C, then 8'hC3) without a clr in between -> OVF=1, UART_DS=8'hC3; then pulse clr -> all four flags 0 and UART_DS still 8'hC3.
- Rx low pulse of 20 clk with k=109 -> false start, return to IDLE, RxRdy stays 0. Separately, assert rst=0 mid-data -> outputs go to 0 immediately; the next full frame is received correctly.
- clr pulsed in the DONE cycle of a frame while RxRdy=1 -> RxRdy stays 1, OVF=0, new data latched.
